// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, 8 data bits LSB first, one stop bit.
// A single-cycle i_TX_DV strobe in IDLE captures i_TX_byte and starts a frame
// on the next cycle. o_TX_done pulses for the first cycle back in IDLE.
// Optional feature macro: UART_PARITY_EN inserts a parity bit between the
// data and stop bits (even parity, or odd parity when PARITY_ODD=1).
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_byte,
    output logic       o_TX_serial,
    output logic       o_TX_active,
    output logic       o_TX_done
);

    localparam int unsigned       CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Parity sense is a single bit; only 0 and 1 are meaningful values.
    if (PARITY_ODD > 1) begin : g_parity_odd_out_of_range
    end

`ifdef UART_PARITY_EN
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        idx_q,    idx_d;
    logic [7:0]        data_q,   data_d;
    logic              serial_q, serial_d;
    logic              active_q, active_d;
    logic              done_q,   done_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // State register and registered outputs; reset forces the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles, the line value for
    // the following bit is registered on the last cycle of the current one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                if (i_TX_DV) begin
                    data_d   = i_TX_byte;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = data_q[0];
                    state_d  = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        serial_d = (^data_q) ^ PARITY_SENSE;
                        state_d  = S_PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = S_STOP;
`endif
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            S_STOP: begin
                serial_d = 1'b1;
                if (bit_end) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
        endcase
    end

    assign o_TX_serial = serial_q;
    assign o_TX_active = active_q;
    assign o_TX_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int unsigned CPB   = 4;
    localparam int unsigned CPB_B = 3;
`ifdef UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic       serial, active, done;
    logic       b_dv = 1'b0;
    logic [7:0] b_byte = 8'h00;
    logic       b_serial, b_active, b_done;

    int          errors = 0;
    int          checks = 0;
    int unsigned done_cnt = 0;
    logic [7:0]  exp_q[$];

    // Monitor state
    bit          mon_busy = 1'b0;
    int unsigned mon_j = 0;
    int unsigned act_cnt = 0;
    logic [10:0] mon_bits = '0;
    logic [7:0]  mon_exp;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_TX_DV     (dv),
        .i_TX_byte   (byte_i),
        .o_TX_serial (serial),
        .o_TX_active (active),
        .o_TX_done   (done)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB_B), .PARITY_ODD(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_TX_DV     (b_dv),
        .i_TX_byte   (b_byte),
        .o_TX_serial (b_serial),
        .o_TX_active (b_active),
        .o_TX_done   (b_done)
    );

    // Line decoder for the main DUT: samples mid-bit, checks each frame at its done cycle
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (!mon_busy && serial === 1'b0) begin
                mon_busy = 1'b1;
                mon_j    = 0;
                act_cnt  = 0;
                mon_bits = '0;
            end
            if (mon_busy) begin
                if (mon_j < FRAME) begin
                    if (active === 1'b1) act_cnt++;
                    if ((mon_j % CPB) == (CPB / 2)) mon_bits[mon_j / CPB] = serial;
                    mon_j++;
                end else begin
                    mon_busy = 1'b0;
                    checks++;
                    if (done !== 1'b1) begin
                        errors++; $display("FAIL frame_done: got %b want 1", done);
                    end
                    checks++;
                    if (active !== 1'b0) begin
                        errors++; $display("FAIL frame_active_end: got %b want 0", active);
                    end
                    checks++;
                    if (act_cnt != FRAME) begin
                        errors++; $display("FAIL frame_active_len: got %0d want %0d", act_cnt, FRAME);
                    end
                    checks++;
                    if (mon_bits[0] !== 1'b0) begin
                        errors++; $display("FAIL frame_start_bit: got %b want 0", mon_bits[0]);
                    end
                    checks++;
                    if (mon_bits[NB-1] !== 1'b1) begin
                        errors++; $display("FAIL frame_stop_bit: got %b want 1", mon_bits[NB-1]);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL frame_unexpected: got %02h want none", mon_bits[8:1]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_bits[8:1] !== mon_exp) begin
                            errors++; $display("FAIL frame_byte: got %02h want %02h", mon_bits[8:1], mon_exp);
                        end
`ifdef UART_PARITY_EN
                        checks++;
                        if (mon_bits[9] !== ^mon_exp) begin
                            errors++; $display("FAIL frame_parity_even: got %b want %b", mon_bits[9], ^mon_exp);
                        end
`endif
                    end
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] b);
        @(posedge clk); #1;
        dv = 1'b1; byte_i = b;
        exp_q.push_back(b);
        @(posedge clk); #1;
        dv = 1'b0; byte_i = ~b;
    endtask

    task automatic wait_done(input int unsigned limit, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b want 1", serial); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int unsigned base;
        bit seen;
        base = done_cnt;
        send_a(8'h55);
        wait_done(FRAME + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_done_timeout: got none want pulse"); end
        #1;
        checks++;
        if (done_cnt != base + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - base, 1); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL basic_idle_line: got %b want 1", serial); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_ignored_strobe();
        int unsigned base;
        bit seen;
        bit quiet;
        base = done_cnt;
        send_a(8'hA3);
        repeat (8) @(posedge clk);
        #1; dv = 1'b1; byte_i = 8'hFF;
        @(posedge clk); #1; dv = 1'b0;
        wait_done(FRAME + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL ignore_done_timeout: got none want pulse"); end
        quiet = 1'b1;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (active !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL ignore_no_second_frame: got active want idle"); end
        #1;
        checks++;
        if (done_cnt != base + 1) begin errors++; $display("FAIL ignore_done_count: got %0d want %0d", done_cnt - base, 1); end
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        bit seen;
        base = done_cnt;
        @(posedge clk); #1;
        dv = 1'b1; byte_i = 8'h00;
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        byte_i = 8'h81;
        exp_q.push_back(8'h81);
        wait_done(FRAME + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_first_timeout: got none want pulse"); end
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL b2b_gap_high: got %b want 1", serial); end
        @(posedge clk); #1;
        dv = 1'b0;
        @(negedge clk);
        checks++;
        if (serial !== 1'b0) begin errors++; $display("FAIL b2b_gap_len: got %b want 0", serial); end
        wait_done(FRAME + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_second_timeout: got none want pulse"); end
        #1;
        checks++;
        if (done_cnt != base + 2) begin errors++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt - base, 2); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int unsigned base;
        bit seen;
        logic [7:0] dropped;
        base = done_cnt;
        send_a(8'h0F);
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if (serial !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL abort_pre_state: got %b%b want 01", serial, active);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (serial !== 1'b1) begin errors++; $display("FAIL abort_async_line: got %b want 1", serial); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b want 0", active); end
        dropped = exp_q.pop_back();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != base || done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %0d/%b want 0/0", done_cnt - base, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        send_a(dropped);
        wait_done(FRAME + 5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_resend_timeout: got none want pulse"); end
        #1;
        checks++;
        if (done_cnt != base + 1) begin errors++; $display("FAIL abort_resend_count: got %0d want %0d", done_cnt - base, 1); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_short_bit_period();
        logic [10:0] bits;
        logic [7:0]  sent;
        logic [7:0]  exp_b[$];
        logic [7:0]  want;
        int unsigned n_act;
        sent = 8'h07;
        exp_b.push_back(sent);
        @(posedge clk); #1;
        b_dv = 1'b1; b_byte = sent;
        @(posedge clk); #1;
        b_dv = 1'b0; b_byte = 8'hFF;
        n_act = 0;
        bits  = '0;
        for (int unsigned j = 0; j < NB * CPB_B; j++) begin
            @(negedge clk);
            if (b_active === 1'b1) n_act++;
            if ((j % CPB_B) == 1) bits[j / CPB_B] = b_serial;
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b1 || b_active !== 1'b0) begin
            errors++; $display("FAIL short_done: got %b%b want 10", b_done, b_active);
        end
        checks++;
        if (n_act != NB * CPB_B) begin errors++; $display("FAIL short_len: got %0d want %0d", n_act, NB * CPB_B); end
        checks++;
        if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) begin
            errors++; $display("FAIL short_framing: got %b%b want 01", bits[0], bits[NB-1]);
        end
        want = exp_b.pop_front();
        checks++;
        if (bits[8:1] !== want) begin errors++; $display("FAIL short_byte: got %02h want %02h", bits[8:1], want); end
`ifdef UART_PARITY_EN
        checks++;
        if (bits[9] !== ~^want) begin errors++; $display("FAIL short_parity_odd: got %b want %b", bits[9], ~^want); end
`endif
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) begin errors++; $display("FAIL short_done_width: got %b want 0", b_done); end
    endtask

    task automatic test_drain();
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_strobe();
        test_back_to_back();
        test_reset_abort();
        test_short_bit_period();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter and the send-side counterpart to the receive path that produces r_DV.
- Accepts one byte with a single-cycle data-valid strobe and shifts it out as 8N1: start bit, 8 data bits LSB first, stop bit.
- Sits between the user/switch pulse logic (which generates the strobe) and the board TX pin.
- Provides busy and done status for LED indicators and upstream sequencing.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600 baud); legal range ≥2.
- PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_TX_DV  input  1  start strobe; sampled only in IDLE.
- i_TX_byte  input  8  byte to send; captured on the accepting edge.
- o_TX_serial  output  1  serial line; idle high.
- o_TX_active  output  1  high while a frame is on the line.
- o_TX_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (async, rst=1): state=IDLE, o_TX_serial=1, o_TX_active=0, o_TX_done=0, bit counter=0, bit index=0, shift register=0. The line goes high immediately, without waiting for a clk edge.
- Bit-period counter width: $clog2(CLKS_PER_BIT). The counter runs 0..CLKS_PER_BIT-1, then clears and the FSM advances. There is no free-running wrap.
- IDLE:
  - o_TX_serial=1, o_TX_active=0.
  - On a clk edge with i_TX_DV=1: latch i_TX_byte, o_TX_serial<=0, o_TX_active<=1, go to START.
  - Zero-cycle latency from strobe edge to start bit.
- START: hold line 0 for CLKS_PER_BIT cycles, then go to DATA with index=0.
- DATA:
  - Drive byte[index] for CLKS_PER_BIT cycles, then index+1.
  - After index 7 completes, go to STOP (or PARITY, see Optional Feature).
  - Index is 3 bits.
- STOP: drive 1 for CLKS_PER_BIT cycles. On the last cycle: o_TX_done<=1, o_TX_active<=0, go to IDLE.
- o_TX_done:
  - High for exactly one cycle, the first cycle back in IDLE.
  - Cleared by the next edge regardless of i_TX_DV.
- Frame length: exactly 10*CLKS_PER_BIT cycles of line activity from the first low cycle through the end of the stop bit.
- Back-to-back: i_TX_DV=1 during the o_TX_done cycle is accepted. The next start bit begins on the following cycle, giving one idle-high cycle between frames.
- i_TX_DV while o_TX_active=1: ignored, not queued. The latched byte is unaffected by later changes to i_TX_byte.
- Reset asserted mid-frame: frame aborted, line forced high, no o_TX_done pulse, return to IDLE.
- i_TX_DV held high continuously: a new frame starts in each IDLE/done cycle, i.e. continuous transmission.
- Encode the FSM as localparams; no unreachable states. Any illegal state recovers to IDLE with the line high.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state follows DATA.
  - It drives ^byte (even) or ~^byte (odd, PARITY_ODD=1) for CLKS_PER_BIT cycles, then goes to STOP.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; 8N1 with a 10-bit frame. The PARITY_ODD parameter still exists but is unused.

Test Plan:
- CLKS_PER_BIT=4, reset, send 0x55 -> line samples (mid-bit) 0,1,0,1,0,1,0,1,0,1. o_TX_active high for 40 cycles. o_TX_done high exactly 1 cycle at cycle 41.
- Send 0xA3, then pulse i_TX_DV with 0xFF at cycle 10 -> second strobe ignored; decoded byte 0xA3; a single o_TX_done.
- Hold i_TX_DV=1 with 0x00 then 0x81 -> two frames separated by exactly 1 high cycle. Bits decode to 0x00 and 0x81; two done pulses.
- Assert rst at cycle 17 of a 0x0F frame -> o_TX_serial=1 within the same cycle (before the next edge); o_TX_active=0; no done; the next strobe sends a clean full frame.
- UART_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0.
- Default CLKS_PER_BIT=10417, send 0x41 -> each bit exactly 10417 cycles; stop ends at cycle 104170.
